// File: rtl/m_updown_counter.sv
// Modulo-N up/down counter with load-clamp and a one-cycle boundary pulse.
// Define M_UPDOWN_COUNTER_SATURATE_EN to hold at the range ends instead of wrapping.
module m_updown_counter #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 10
) (
    input  logic             w_clock,
    input  logic             w_reset,
    input  logic             w_enable,
    input  logic             w_up,
    input  logic             w_load,
    input  logic [WIDTH-1:0] w_load_value,
    output logic [WIDTH-1:0] w_count,
    output logic             w_wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    // One extra bit so MODULO = 2**WIDTH is representable in the clamp compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;

    // Next-state: load beats count step beats hold; only a step can raise the pulse.
    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        if (w_load) begin
            w_next_count = ({1'b0, w_load_value} < MOD_EXT) ? w_load_value : MAX_VAL;
        end else if (w_enable) begin
            if (w_up) begin
                if (r_count == MAX_VAL) begin
                    w_next_wrap = 1'b1;
`ifdef M_UPDOWN_COUNTER_SATURATE_EN
                    w_next_count = MAX_VAL;
`else
                    w_next_count = '0;
`endif
                end else begin
                    w_next_count = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_next_wrap = 1'b1;
`ifdef M_UPDOWN_COUNTER_SATURATE_EN
                    w_next_count = '0;
`else
                    w_next_count = MAX_VAL;
`endif
                end else begin
                    w_next_count = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
        end
    end

    assign w_count = r_count;
    assign w_wrap  = r_wrap;

endmodule
